grf_scoreboard: RTL and testbench
=================================

Name: grf_scoreboard

Overview:
- Pending-write tracker for the 32-entry general register file; it is the read-side companion of the GRF write port.
- Decode issues a destination register when an instruction enters the pipe. Writeback retires it on the same WA/WE strobe that writes the GRF.
- Two read-check ports report whether a source register still has an outstanding write, which drives the stall logic.
- Sits between decode/issue and the GRF write port in the pipelined MIPS core.

Parameters:
- CNT_W, 2, width of each per-register pending counter. Max in-flight writes per register is 2^CNT_W-1.
- NREG, 32, number of architectural registers. Index width is fixed at 5.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- iss_valid  input  1  decode requests to issue an instruction with a destination register.
- iss_ready  output  1  scoreboard can accept the issue this cycle.
- iss_wa  input  5  destination register of the issuing instruction.
- WE  input  1  writeback strobe, identical to the GRF write enable.
- WA  input  5  writeback register, identical to the GRF write address.
- RA1  input  5  source register 1 to check.
- RA2  input  5  source register 2 to check.
- busy1  output  1  RA1 has at least one pending write.
- busy2  output  1  RA2 has at least one pending write.
- stall  output  1  busy1 | busy2 | (iss_valid & ~iss_ready).
- pending_total  output  8  sum of all pending counters, for debug.
- err_underflow  output  1  sticky flag: a retire arrived for a register whose counter was 0.

Behaviour:
- Reset (reset==0, asynchronous): all counters 0, err_underflow 0, pending_total 0. Result: iss_ready=1, busy1=busy2=0, stall=0.
- Issue handshake: the issue fires on a rising edge when iss_valid & iss_ready & (iss_wa!=0). The cnt[iss_wa] counter increments by 1.
  - iss_wa==0 always reports iss_ready=1 and never changes state.
- iss_ready is combinational: 0 only when cnt[iss_wa] is at the all-ones value and no retire to the same register occurs this cycle. Otherwise 1.
  - When iss_ready=0, decode holds iss_valid and iss_wa stable.
- Retire: on a rising edge with WE==1 and WA!=0, cnt[WA] decrements by 1.
  - WA==0 is ignored.
  - A retire on a zero counter leaves the counter at 0 and sets err_underflow. err_underflow clears only on reset.
- Simultaneous issue and retire:
  - Same register: the counter is unchanged (net 0), and the issue is accepted even at saturation.
  - Different registers: both updates apply in the same cycle.
- busy1/busy2 are combinational on the current registered counters: busyN = (RAN!=0) & (cnt[RAN]!=0).
  - A retire in the current cycle does not clear busy until the next cycle. The GRF has no internal write-to-read bypass, so the value is read after the edge.
- pending_total is registered and updated every edge: previous + fired issue - effective retire. It never wraps: max is 31*(2^CNT_W-1) = 93 for the default.
- Mid-operation reset: all state clears immediately, with no dependency on clk. In-flight writebacks arriving after reset deasserts are counted as underflow.
- Latency:
  - Issue to busy visible: 1 cycle.
  - Retire to busy cleared: 1 cycle.

Decomposition:
- Shared package holds the register-index width constant (5), NREG, the $0 index constant, and the counter width default.
- One natural sub-module, sb_counter: a single saturating up/down counter with inc, dec, and a zero/full flag, plus an underflow pulse. It is instantiated 31 times ($1..$31); $0 is tied to zero.

Test Plan:
- Reset then idle:
  - Drive reset low for 2 cycles, then high. Set RA1=5, RA2=0.
  - Required: busy1=0, busy2=0, stall=0, iss_ready=1, pending_total=0.
- Issue then retire:
  - Issue iss_wa=8. Next cycle set RA1=8.
  - Required: busy1=1, stall=1, pending_total=1.
  - Then pulse WE with WA=8. Required one cycle later: busy1=0, pending_total=0.
- Saturation:
  - Issue iss_wa=3 three times.
  - Required: cnt=3 and iss_ready=0 for a fourth issue, with stall=1.
  - Then drive issue iss_wa=3 together with WE with WA=3 in one cycle. Required: accepted, counter stays 3, pending_total=3.
- $0 handling:
  - Issue iss_wa=0, then pulse WE with WA=0. Set RA1=0.
  - Required: busy1=0, pending_total=0, err_underflow=0.
- Underflow:
  - With all counters 0, pulse WE with WA=17.
  - Required: err_underflow=1 and sticky, cnt[17]=0, pending_total=0.
- Async reset mid-operation:
  - Issue regs 4, 9, 9. Assert reset between clock edges.
  - Required: all outputs return to reset values before the next rising edge.

Source files
------------

// File: rtl/grf_scoreboard_pkg.sv
// Shared constants for the GRF pending-write scoreboard.
package grf_scoreboard_pkg;

    localparam int REG_W     = 5;              // register index width
    localparam int NREG      = 32;             // architectural registers
    localparam int CNT_W_DEF = 2;              // default pending-counter width
    localparam int TOT_W     = 8;              // pending_total width

    localparam logic [REG_W-1:0] REG_ZERO = '0; // $0, hardwired zero

endpackage

// File: rtl/grf_scoreboard_sb_counter.sv
// One per-register pending-write counter: saturating up/down with
// zero/full flags and an underflow pulse on retire-from-empty.
import grf_scoreboard_pkg::*;

module sb_counter #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic full_o,
    output logic udf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign zero_o = (cnt_q == '0);
    assign full_o = (cnt_q == '1);

    // Next count: issue+retire together is a no-op (even at 0 or full),
    // a lone retire on an empty counter holds at 0 and flags underflow.
    always_comb begin
        cnt_d = cnt_q;
        udf_o = 1'b0;
        unique case ({inc_i, dec_i})
            2'b10: if (!full_o) cnt_d = cnt_q + CNT_W'(1);
            2'b01: begin
                if (zero_o) udf_o = 1'b1;
                else        cnt_d = cnt_q - CNT_W'(1);
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/grf_scoreboard.sv
// GRF pending-write scoreboard: decode issues destinations, writeback
// retires them on the GRF write strobe, two read ports report busy.
import grf_scoreboard_pkg::*;

module grf_scoreboard #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [REG_W-1:0] iss_wa,
    input  logic             WE,
    input  logic [REG_W-1:0] WA,
    input  logic [REG_W-1:0] RA1,
    input  logic [REG_W-1:0] RA2,
    output logic             busy1,
    output logic             busy2,
    output logic             stall,
    output logic [TOT_W-1:0] pending_total,
    output logic             err_underflow
);

    logic [NREG-1:0] inc_w, dec_w, zero_w, full_w, udf_w;
    logic            iss_fire, ret_vld, ret_eff;
    logic [TOT_W-1:0] total_q, total_d;
    logic            err_q, err_d;

    // $0 never holds a pending write.
    assign zero_w[0] = 1'b1;
    assign full_w[0] = 1'b0;
    assign udf_w[0]  = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_cnt
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk_i  (clk),
                .rst_ni (reset),
                .inc_i  (inc_w[gi]),
                .dec_i  (dec_w[gi]),
                .zero_o (zero_w[gi]),
                .full_o (full_w[gi]),
                .udf_o  (udf_w[gi])
            );
        end
    endgenerate

    // A retire to the same register frees a slot, so a full counter may
    // still accept an issue in that cycle.
    assign ret_vld   = WE && (WA != REG_ZERO);
    assign iss_ready = (iss_wa == REG_ZERO) || !full_w[iss_wa] ||
                       (ret_vld && (WA == iss_wa));
    assign iss_fire  = iss_valid && iss_ready && (iss_wa != REG_ZERO);
    assign ret_eff   = ret_vld && !udf_w[WA];

    // Decode the one-hot increment/decrement strobes per register.
    always_comb begin
        inc_w = '0;
        dec_w = '0;
        if (iss_fire) inc_w[iss_wa] = 1'b1;
        if (ret_vld)  dec_w[WA]     = 1'b1;
    end

    // Busy looks only at registered counts; the GRF has no bypass.
    assign busy1 = (RA1 != REG_ZERO) && !zero_w[RA1];
    assign busy2 = (RA2 != REG_ZERO) && !zero_w[RA2];
    assign stall = busy1 || busy2 || (iss_valid && !iss_ready);

    // Running total follows the counters exactly, so it cannot wrap.
    always_comb begin
        total_d = total_q + TOT_W'(iss_fire) - TOT_W'(ret_eff);
        err_d   = err_q || (|udf_w);
    end

    // Debug total and sticky underflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    assign pending_total = total_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench: stimulus queues expected outputs, a negedge monitor
// pops one expectation per cycle and compares it to the DUT.
module tb_grf_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       iss_valid, iss_ready;
    logic [4:0] iss_wa, WA, RA1, RA2;
    logic       WE;
    logic       busy1, busy2, stall, err_underflow;
    logic [7:0] pending_total;

    typedef struct {
        string      name;
        logic       b1, b2, st, rdy;
        logic [7:0] tot;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    grf_scoreboard dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_wa(iss_wa),
        .WE(WE), .WA(WA), .RA1(RA1), .RA2(RA2),
        .busy1(busy1), .busy2(busy2), .stall(stall),
        .pending_total(pending_total), .err_underflow(err_underflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string n, input logic b1, input logic b2,
                              input logic st, input logic rdy,
                              input logic [7:0] tot, input logic err);
        exp_t e;
        e.name = n; e.b1 = b1; e.b2 = b2; e.st = st; e.rdy = rdy;
        e.tot = tot; e.err = err;
        exp_q.push_back(e);
    endtask

    // Monitor: compare one queued expectation each falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            nvec++;
            if (busy1 !== e.b1 || busy2 !== e.b2 || stall !== e.st ||
                iss_ready !== e.rdy || pending_total !== e.tot ||
                err_underflow !== e.err) begin
                nerr++;
                $display("FAIL %s: got b1=%b b2=%b stall=%b rdy=%b tot=%0d err=%b, want b1=%b b2=%b stall=%b rdy=%b tot=%0d err=%b",
                         e.name, busy1, busy2, stall, iss_ready, pending_total,
                         err_underflow, e.b1, e.b2, e.st, e.rdy, e.tot, e.err);
            end
        end
    end

    initial begin
        reset = 1'b0; iss_valid = 1'b0; iss_wa = 5'd0;
        WE = 1'b0; WA = 5'd0; RA1 = 5'd5; RA2 = 5'd0;

        // Reset then idle
        step();
        expect_out("rst_hold", 0, 0, 0, 1, 8'd0, 0);
        step();
        reset = 1'b1;
        expect_out("idle", 0, 0, 0, 1, 8'd0, 0);

        // Issue then retire $8
        step();
        iss_valid = 1'b1; iss_wa = 5'd8;
        expect_out("iss8_pre", 0, 0, 0, 1, 8'd0, 0);
        step();
        iss_valid = 1'b0; RA1 = 5'd8;
        expect_out("busy8", 1, 0, 1, 1, 8'd1, 0);
        step();
        WE = 1'b1; WA = 5'd8;
        expect_out("ret8_same_cyc", 1, 0, 1, 1, 8'd1, 0);
        step();
        WE = 1'b0; RA1 = 5'd0;
        expect_out("ret8_done", 0, 0, 0, 1, 8'd0, 0);

        // Saturation on $3
        step();
        iss_valid = 1'b1; iss_wa = 5'd3;
        step();
        step();
        step();
        RA2 = 5'd3;
        expect_out("sat_full", 0, 1, 1, 0, 8'd3, 0);
        step();
        WE = 1'b1; WA = 5'd3;
        expect_out("sat_same_ret", 0, 1, 1, 1, 8'd3, 0);
        step();
        WE = 1'b0;
        expect_out("sat_still3", 0, 1, 1, 0, 8'd3, 0);
        step();
        iss_valid = 1'b0; WE = 1'b1; WA = 5'd3;
        step();
        step();
        step();
        WE = 1'b0;
        expect_out("drain", 0, 0, 0, 1, 8'd0, 0);

        // $0 handling
        step();
        RA2 = 5'd0; iss_valid = 1'b1; iss_wa = 5'd0;
        expect_out("zero_iss", 0, 0, 0, 1, 8'd0, 0);
        step();
        iss_valid = 1'b0; WE = 1'b1; WA = 5'd0;
        step();
        WE = 1'b0; RA1 = 5'd0;
        expect_out("zero_after", 0, 0, 0, 1, 8'd0, 0);

        // Underflow on $17
        step();
        WE = 1'b1; WA = 5'd17; RA1 = 5'd17;
        expect_out("udf_pre", 0, 0, 0, 1, 8'd0, 0);
        step();
        WE = 1'b0;
        expect_out("udf_set", 0, 0, 0, 1, 8'd0, 1);
        step();
        step();
        expect_out("udf_sticky", 0, 0, 0, 1, 8'd0, 1);
        step();
        iss_valid = 1'b1; iss_wa = 5'd17;
        step();
        iss_valid = 1'b0; WE = 1'b1; WA = 5'd17;
        expect_out("udf_iss17", 1, 0, 1, 1, 8'd1, 1);
        step();
        WE = 1'b0;
        expect_out("udf_cnt0", 0, 0, 0, 1, 8'd0, 1);

        // Async reset mid-operation
        step();
        iss_valid = 1'b1; iss_wa = 5'd4;
        step();
        iss_wa = 5'd9;
        step();
        step();
        iss_valid = 1'b0; RA1 = 5'd4; RA2 = 5'd9;
        expect_out("pre_rst", 1, 1, 1, 1, 8'd3, 1);
        step();
        #2;
        reset = 1'b0;
        expect_out("async_rst", 0, 0, 0, 1, 8'd0, 0);
        step();
        reset = 1'b1; WE = 1'b1; WA = 5'd9;
        step();
        WE = 1'b0;
        expect_out("post_rst_udf", 0, 0, 0, 1, 8'd0, 1);

        // Drain the expectation queue with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
        if (exp_q.size() > 0) begin
            nerr++;
            $display("FAIL drain_timeout: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
